// File: rtl/fifo_burst_drain.sv
// Read-side drain stage for a show-ahead syncfifo: pops beats into a 2-entry skid buffer,
// forwards them on valid/ready, tracks burst framing for boundary-aligned pause, and counts packets.
module fifo_burst_drain #(
    parameter int WID      = 32,
    parameter int LASTBIT  = 0,
    parameter int MAXBEATS = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           softreset,
    input  logic           fifo_empty,
    input  logic [WID-1:0] fifo_dout,
    output logic           fifo_readout,
    output logic           vldout,
    output logic [WID-1:0] dout,
    input  logic           ready,
    input  logic           pause,
    output logic           paused,
    output logic           pkt_done,
    output logic [15:0]    pkt_count,
    output logic           err_overlong
);

    localparam int CNTW = $clog2(MAXBEATS + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXBEATS);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CNTW-1:0] beat_cnt;
    logic [CNTW-1:0] beat_cnt_next;
    logic [1:0]      occ;
    logic [WID-1:0]  skid_head;
    logic [WID-1:0]  skid_tail;
    logic            clr;
    logic            pop;
    logic            accept;

    assign clr    = rst || softreset;
    assign vldout = (occ != 2'd0);
    assign dout   = skid_head;
    assign accept = vldout && ready;

    // A full skid may still pop when a beat leaves in the same cycle; reset blocks popping outright.
    assign pop = !clr && !fifo_empty && !(state == IDLE && pause)
                 && ((occ != 2'd2) || accept);

    assign fifo_readout = pop;
    assign paused       = !clr && (state == IDLE) && pause;

    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            err_overlong <= 1'b0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            if (state_next == BURST && beat_cnt_next == CNT_MAX) begin
                err_overlong <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        if (pop) begin
            case (state)
                IDLE: begin
                    if (!fifo_dout[LASTBIT]) begin
                        state_next    = BURST;
                        beat_cnt_next = CNTW'(1);
                    end
                end
                BURST: begin
                    if (fifo_dout[LASTBIT]) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else if (beat_cnt != CNT_MAX) begin
                        beat_cnt_next = beat_cnt + CNTW'(1);
                    end
                end
                default: begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            occ <= 2'd0;
        end else begin
            case ({pop, accept})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Skid payload carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        case ({pop, accept})
            2'b10: begin
                if (occ == 2'd0) begin
                    skid_head <= fifo_dout;
                end else begin
                    skid_tail <= fifo_dout;
                end
            end
            2'b01: begin
                skid_head <= skid_tail;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    skid_head <= fifo_dout;
                end else begin
                    skid_head <= skid_tail;
                    skid_tail <= fifo_dout;
                end
            end
            default: begin
                skid_head <= skid_head;
                skid_tail <= skid_tail;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pkt_done  <= 1'b0;
            pkt_count <= 16'd0;
        end else begin
            pkt_done <= accept && dout[LASTBIT];
            if (accept && dout[LASTBIT]) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain: a queue models the syncfifo, stimulus pushes expected
// beats, and a negedge monitor checks order, hold-stability, pkt_done and pkt_count.
module tb_fifo_burst_drain;

    localparam int WID      = 32;
    localparam int LASTBIT  = 0;
    localparam int MAXBEATS = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           softreset;
    logic           fifo_empty;
    logic [WID-1:0] fifo_dout;
    logic           fifo_readout;
    logic           vldout;
    logic [WID-1:0] dout;
    logic           ready;
    logic           pause;
    logic           paused;
    logic           pkt_done;
    logic [15:0]    pkt_count;
    logic           err_overlong;

    logic [WID-1:0] fq[$];
    logic [WID-1:0] exp_q[$];
    int             tests = 0;
    int             fails = 0;
    int             pops  = 0;

    fifo_burst_drain #(
        .WID(WID),
        .LASTBIT(LASTBIT),
        .MAXBEATS(MAXBEATS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .softreset(softreset),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_readout(fifo_readout),
        .vldout(vldout),
        .dout(dout),
        .ready(ready),
        .pause(pause),
        .paused(paused),
        .pkt_done(pkt_done),
        .pkt_count(pkt_count),
        .err_overlong(err_overlong)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WID-1:0] beat(input int tag, input bit last);
        return (WID'(tag) << 1) | WID'(last);
    endfunction

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [WID-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget, output int used);
        used = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && used < budget) begin
            tick(1);
            used++;
        end
        check(name, WID'(exp_q.size()), '0);
    endtask

    // syncfifo model: show-ahead head, popped on readout
    always @(posedge clk) begin
        if (fifo_readout) begin
            if (fq.size() != 0) begin
                void'(fq.pop_front());
                pops++;
            end else begin
                tests++;
                fails++;
                $display("FAIL pop_on_empty: readout=1 with empty FIFO at %0t", $time);
            end
        end
        #1 refresh();
    end

    logic [WID-1:0] e;
    logic [WID-1:0] hold_d;
    bit             hold      = 1'b0;
    bit             done_pend = 1'b0;
    logic [15:0]    exp_pkts  = 16'd0;

    always @(negedge clk) begin
        if (rst || softreset) begin
            hold      = 1'b0;
            done_pend = 1'b0;
            exp_pkts  = 16'd0;
        end else begin
            check("pkt_done", WID'(pkt_done), WID'(done_pend));
            if (done_pend) check("pkt_count", WID'(pkt_count), WID'(exp_pkts));
            if (hold) begin
                check("hold_vld", WID'(vldout), WID'(1));
                check("hold_dout", dout, hold_d);
            end
            done_pend = 1'b0;
            if (vldout && ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got %0h, expected no beat at %0t", dout, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e);
                    if (e[LASTBIT]) begin
                        done_pend = 1'b1;
                        exp_pkts  = exp_pkts + 16'd1;
                    end
                end
            end
            hold   = vldout && !ready;
            hold_d = dout;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int p0;
        int n;
        rst       = 1'b1;
        softreset = 1'b0;
        ready     = 1'b0;
        pause     = 1'b0;
        refresh();

        // reset with a non-empty FIFO
        push(beat(1, 1'b1));
        tick(1);
        check("rst_readout_0", WID'(fifo_readout), '0);
        tick(1);
        check("rst_readout_1", WID'(fifo_readout), '0);
        check("rst_vldout", WID'(vldout), '0);
        check("rst_pkt_count", WID'(pkt_count), '0);
        check("rst_err", WID'(err_overlong), '0);
        check("rst_paused", WID'(paused), '0);
        rst   = 1'b0;
        ready = 1'b1;
        tick(1);
        check("latency_vld", WID'(vldout), WID'(1));
        check("latency_dout", dout, beat(1, 1'b1));
        wait_drain("t1_drain", 10, used);

        // streaming 8 beats at full rate
        for (int i = 0; i < 8; i++) push(beat(16 + i, i == 7));
        wait_drain("t2_drain", 20, used);
        check("t2_cycles", WID'(used), WID'(9));
        check("t2_pkt_count", WID'(pkt_count), WID'(2));
        check("t2_err_8beats", WID'(err_overlong), WID'(1));

        softreset = 1'b1;
        tick(1);
        softreset = 1'b0;
        check("srst_err", WID'(err_overlong), '0);
        check("srst_pkt_count", WID'(pkt_count), '0);
        check("srst_vldout", WID'(vldout), '0);

        // overlong burst
        for (int i = 1; i <= 6; i++) begin
            push(beat(32 + i, 1'b0));
            tick(1);
            check("t5_err", WID'(err_overlong), WID'(i >= MAXBEATS));
        end
        pause = 1'b1;
        #1;
        check("t5_paused_burst", WID'(paused), '0);
        #1;
        push(beat(39, 1'b1));
        tick(1);
        check("t5_paused_idle", WID'(paused), WID'(1));
        check("t5_err_sticky", WID'(err_overlong), WID'(1));
        pause = 1'b0;
        wait_drain("t5_drain", 10, used);

        // backpressure
        for (int i = 0; i < 4; i++) push(beat(48 + i, i == 3));
        tick(1);
        ready = 1'b0;
        tick(2);
        check("t3_vld", WID'(vldout), WID'(1));
        check("t3_readout", WID'(fifo_readout), '0);
        check("t3_fifo_left", WID'(fq.size()), WID'(2));
        tick(3);
        ready = 1'b1;
        wait_drain("t3_drain", 12, used);

        // pause raised mid-burst
        p0 = pops;
        for (int i = 0; i < 4; i++) push(beat(64 + i, i == 3));
        for (int i = 0; i < 2; i++) push(beat(80 + i, i == 1));
        n = 0;
        while (pops < p0 + 2 && n < 20) begin
            tick(1);
            n++;
        end
        check("t4_two_popped", WID'(pops - p0), WID'(2));
        pause = 1'b1;
        tick(4);
        check("t4_paused", WID'(paused), WID'(1));
        check("t4_fifo_left", WID'(fq.size()), WID'(2));
        check("t4_readout", WID'(fifo_readout), '0);
        pause = 1'b0;
        #1;
        check("t4_unpaused", WID'(paused), '0);
        wait_drain("t4_drain", 12, used);

        // pkt_count wrap
        softreset = 1'b1;
        tick(1);
        softreset = 1'b0;
        for (int i = 0; i < 65535; i++) push(beat(i, 1'b1));
        wait_drain("t6_bulk_drain", 70000, used);
        check("t6_count_ffff", WID'(pkt_count), WID'(16'hFFFF));
        push(beat(7, 1'b1));
        wait_drain("t6_wrap_drain", 10, used);
        check("t6_count_wrap", WID'(pkt_count), '0);

        // softreset with a full skid
        ready = 1'b0;
        push(beat(90, 1'b0));
        push(beat(91, 1'b1));
        tick(3);
        check("t6_full_vld", WID'(vldout), WID'(1));
        check("t6_full_fifo", WID'(fq.size()), '0);
        softreset = 1'b1;
        tick(1);
        softreset = 1'b0;
        exp_q.delete();
        check("t6_srst_vld", WID'(vldout), '0);
        ready = 1'b1;
        tick(2);
        check("t6_srst_vld_later", WID'(vldout), '0);
        check("t6_srst_count", WID'(pkt_count), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
